// File: rtl/jpeg_pkg.sv
// Shared constants and types for the JPEG quantization path.
package jpeg_pkg;

   localparam int unsigned BLK_W  = 1024;
   localparam int unsigned COEF_W = 16;

   localparam logic COMP_LUMA   = 1'b0;
   localparam logic COMP_CHROMA = 1'b1;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StResult,
      StClear
   } qs_state_e;

endpackage

// File: rtl/quant_table_regs.sv
// Luma and chroma quantization table registers, written one full table per strobe.
module quant_table_regs
   import jpeg_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             we_i,
   input  logic             sel_i,
   input  logic [BLK_W-1:0] data_i,
   output logic [BLK_W-1:0] luma_o,
   output logic [BLK_W-1:0] chroma_o
);

   logic [BLK_W-1:0] luma_q, chroma_q;

   // Table store; a write is visible from the following cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         luma_q   <= '0;
         chroma_q <= '0;
      end else if (we_i) begin
         if (sel_i == COMP_CHROMA) chroma_q <= data_i;
         else                      luma_q   <= data_i;
      end
   end

   assign luma_o   = luma_q;
   assign chroma_o = chroma_q;

endmodule

// File: rtl/quant_scheduler.sv
// Sequencer for one 8x8 quantization operation at a time: accept, run, return, clear.
module quant_scheduler
   import jpeg_pkg::*;
#(
   parameter int unsigned TIMEOUT = 256,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             Clock,
   input  logic             reset,
   input  logic             tbl_we,
   input  logic             tbl_sel,
   input  logic [BLK_W-1:0] tbl_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BLK_W-1:0] in_data,
   input  logic             in_comp,
   output logic [BLK_W-1:0] q_A,
   output logic [BLK_W-1:0] q_B,
   output logic             q_Enable,
   input  logic [BLK_W-1:0] q_C,
   input  logic             q_done,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BLK_W-1:0] out_data,
   output logic             out_comp,
   output logic [CNT_W-1:0] blk_count,
   output logic             timeout_err
);

   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] CntLast = TW'(TIMEOUT - 1);

   qs_state_e        state_q, state_d;
   logic [TW-1:0]    cnt_q, cnt_d;
   logic [BLK_W-1:0] q_a_q, q_b_q, out_data_q;
   logic             out_comp_q, timeout_err_q;
   logic [CNT_W-1:0] blk_count_q;
   logic [BLK_W-1:0] luma_tbl, chroma_tbl;
   logic             accept, capture, retire, abort;

   quant_table_regs u_tables (
      .clk_i    (Clock),
      .rst_ni   (reset),
      .we_i     (tbl_we),
      .sel_i    (tbl_sel),
      .data_i   (tbl_data),
      .luma_o   (luma_tbl),
      .chroma_o (chroma_tbl)
   );

   // Next-state, watchdog count and state-decoded handshake outputs.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      accept    = 1'b0;
      capture   = 1'b0;
      retire    = 1'b0;
      abort     = 1'b0;
      in_ready  = 1'b0;
      q_Enable  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept  = 1'b1;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            q_Enable = 1'b1;
            // A done arriving on the last allowed cycle still wins over the abort.
            if (q_done) begin
               capture = 1'b1;
               state_d = StResult;
            end else if (cnt_q == CntLast) begin
               abort   = 1'b1;
               state_d = StClear;
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end
         StResult: begin
            out_valid = 1'b1;
            if (out_ready) begin
               retire  = 1'b1;
               state_d = StClear;
            end
         end
         StClear: begin
            // Hold off the next Enable until the datapath has dropped done.
            if (!q_done) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State register and watchdog counter.
   always_ff @(posedge Clock or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Operand snapshot, result capture, completed-block count and sticky abort flag.
   always_ff @(posedge Clock or negedge reset) begin
      if (!reset) begin
         q_a_q         <= '0;
         q_b_q         <= '0;
         out_comp_q    <= COMP_LUMA;
         out_data_q    <= '0;
         blk_count_q   <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         if (accept) begin
            q_a_q      <= in_data;
            q_b_q      <= (in_comp == COMP_CHROMA) ? chroma_tbl : luma_tbl;
            out_comp_q <= in_comp;
         end
         if (capture) out_data_q    <= q_C;
         if (retire)  blk_count_q   <= blk_count_q + CNT_W'(1);
         if (abort)   timeout_err_q <= 1'b1;
      end
   end

   assign q_A         = q_a_q;
   assign q_B         = q_b_q;
   assign out_data    = out_data_q;
   assign out_comp    = out_comp_q;
   assign blk_count   = blk_count_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_quant_scheduler.sv
// Directed and randomized checks of quant_scheduler against a block-level reference model.
module tb_quant_scheduler;

   localparam int BW = 1024;

   logic          Clock, reset;
   logic          tbl_we, tbl_sel, in_valid, in_comp, out_ready;
   logic [BW-1:0] tbl_data, in_data, q_C;
   logic          q_done;
   logic          in_ready, q_Enable, out_valid, out_comp, timeout_err;
   logic [BW-1:0] q_A, q_B, out_data;
   logic [15:0]   blk_count;

   int checks = 0;
   int errors = 0;

   // Reference model: table contents as written, expected completed-block count.
   logic [BW-1:0] ltab, ctab;
   int            exp_cnt;

   // Stub datapath controls.
   int stub_delay = 5;
   int stub_hold  = 0;
   bit stub_never = 0;
   int stub_cnt, hold_cnt;

   quant_scheduler #(.TIMEOUT(256), .CNT_W(16)) dut (
      .Clock       (Clock),
      .reset       (reset),
      .tbl_we      (tbl_we),
      .tbl_sel     (tbl_sel),
      .tbl_data    (tbl_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_comp     (in_comp),
      .q_A         (q_A),
      .q_B         (q_B),
      .q_Enable    (q_Enable),
      .q_C         (q_C),
      .q_done      (q_done),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_comp    (out_comp),
      .blk_count   (blk_count),
      .timeout_err (timeout_err)
   );

   always #5 Clock = ~Clock;

   // Stub datapath: done stub_delay cycles into Enable, result A xor B, done held stub_hold extra.
   always @(posedge Clock or negedge reset) begin
      if (!reset) begin
         stub_cnt <= 0;
         hold_cnt <= 0;
         q_done   <= 1'b0;
         q_C      <= '0;
      end else if (q_Enable) begin
         hold_cnt <= 0;
         if (!q_done && !stub_never) begin
            if (stub_cnt == stub_delay - 1) begin
               q_done <= 1'b1;
               q_C    <= q_A ^ q_B;
            end
            stub_cnt <= stub_cnt + 1;
         end
      end else begin
         stub_cnt <= 0;
         if (q_done) begin
            if (hold_cnt >= stub_hold) q_done <= 1'b0;
            else                       hold_cnt <= hold_cnt + 1;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      int idx;
      idx = 0;
      for (int i = 0; i < 64; i++) begin
         if (obs[i*16 +: 16] !== exp[i*16 +: 16]) begin
            idx = i;
            break;
         end
      end
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: entry %0d observed %h expected %h", tag, idx, obs[idx*16 +: 16],
                exp[idx*16 +: 16]);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      @(negedge Clock);
   endtask

   function automatic logic [BW-1:0] rand_blk();
      logic [BW-1:0] v;
      for (int i = 0; i < 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic write_tbl(input logic sel, input logic [BW-1:0] d);
      tbl_we   = 1'b1;
      tbl_sel  = sel;
      tbl_data = d;
      tick();
      tbl_we = 1'b0;
      if (sel) ctab = d;
      else     ltab = d;
   endtask

   // Offer a block and return after the accepting edge (at the following negedge).
   task automatic send_block(input logic [BW-1:0] d, input logic c, output bit ok);
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         if (in_ready === 1'b1) begin
            ok = 1;
            break;
         end
         tick();
      end
      if (ok) begin
         in_valid = 1'b1;
         in_data  = d;
         in_comp  = c;
         tick();
         in_valid = 1'b0;
      end
   endtask

   task automatic wait_done(output bit ok);
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         if (q_done === 1'b1) begin
            ok = 1;
            break;
         end
         tick();
      end
   endtask

   // Full block with out_ready high; expected result is data xor table-at-accept.
   task automatic run_block(input string tag, input logic [BW-1:0] d, input logic c,
                            input bit mid_wr);
      logic [BW-1:0] tab;
      bit            ok;
      tab = c ? ctab : ltab;
      send_block(d, c, ok);
      chk({tag, "_accept"}, BW'(ok), BW'(1));
      chk({tag, "_qA"}, q_A, d);
      chk({tag, "_qB"}, q_B, tab);
      chk({tag, "_enable"}, BW'(q_Enable), BW'(1));
      chk({tag, "_done_low_at_enable"}, BW'(q_done), BW'(0));
      if (mid_wr) write_tbl(1'($urandom_range(0, 1)), rand_blk());
      wait_done(ok);
      chk({tag, "_done_seen"}, BW'(ok), BW'(1));
      tick();
      chk({tag, "_out_valid"}, BW'(out_valid), BW'(1));
      chk({tag, "_enable_off"}, BW'(q_Enable), BW'(0));
      chk({tag, "_out_data"}, out_data, d ^ tab);
      chk({tag, "_out_comp"}, BW'(out_comp), BW'(c));
      tick();
      exp_cnt++;
      chk({tag, "_blk_count"}, BW'(blk_count), BW'(16'(exp_cnt)));
   endtask

   initial begin
      logic [BW-1:0] d, t, expv, held;
      bit            ok, saw_valid;
      int            en_cycles;

      Clock     = 1'b0;
      reset     = 1'b0;
      tbl_we    = 1'b0;
      tbl_sel   = 1'b0;
      tbl_data  = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_comp   = 1'b0;
      out_ready = 1'b1;
      ltab      = '0;
      ctab      = '0;
      exp_cnt   = 0;

      // Reset values
      #3;
      chk("rst_in_ready", BW'(in_ready), BW'(1));
      chk("rst_enable", BW'(q_Enable), BW'(0));
      chk("rst_out_valid", BW'(out_valid), BW'(0));
      chk("rst_blk_count", BW'(blk_count), BW'(0));
      chk("rst_timeout_err", BW'(timeout_err), BW'(0));
      chk("rst_qA", q_A, '0);
      chk("rst_qB", q_B, '0);
      chk("rst_out_data", out_data, '0);
      chk("rst_out_comp", BW'(out_comp), BW'(0));
      @(negedge Clock);
      reset = 1'b1;
      tick();

      // Basic block with the luma table
      t = rand_blk();
      t[0*16 +: 16] = 16'd16;  t[1*16 +: 16] = 16'd11;  t[2*16 +: 16] = 16'd10;
      t[3*16 +: 16] = 16'd16;  t[4*16 +: 16] = 16'd24;  t[5*16 +: 16] = 16'd40;
      t[6*16 +: 16] = 16'd51;  t[7*16 +: 16] = 16'd61;
      write_tbl(1'b0, t);
      d = rand_blk();
      d[15:0] = 16'd154;
      run_block("basic", d, 1'b0, 1'b0);
      chk("basic_entry00", BW'(out_data[15:0]), BW'(16'd138));

      // Chroma select
      t = rand_blk();
      t[15:0] = 16'd17;
      write_tbl(1'b1, t);
      run_block("chroma", rand_blk(), 1'b1, 1'b0);
      chk("chroma_qB_entry00", BW'(q_B[15:0]), BW'(16'd17));
      chk("chroma_out_comp_held", BW'(out_comp), BW'(1));

      // Backpressure: out_ready low for 20 cycles
      out_ready = 1'b0;
      d = rand_blk();
      expv = d ^ ltab;
      send_block(d, 1'b0, ok);
      chk("bp_accept", BW'(ok), BW'(1));
      wait_done(ok);
      chk("bp_done_seen", BW'(ok), BW'(1));
      tick();
      held = out_data;
      chk("bp_out_data", held, expv);
      for (int i = 0; i < 20; i++) begin
         chk("bp_out_valid", BW'(out_valid), BW'(1));
         chk("bp_out_stable", out_data, expv);
         chk("bp_in_ready", BW'(in_ready), BW'(0));
         chk("bp_enable", BW'(q_Enable), BW'(0));
         tick();
      end
      out_ready = 1'b1;
      tick();
      exp_cnt++;
      chk("bp_blk_count", BW'(blk_count), BW'(16'(exp_cnt)));
      chk("bp_out_data_held", out_data, expv);
      run_block("bp_resume", rand_blk(), 1'b0, 1'b0);

      // Table write on the same edge as an accept
      @(negedge Clock);
      for (int i = 0; i < 100 && in_ready !== 1'b1; i++) tick();
      d = rand_blk();
      t = ltab;
      t[15:0] = 16'd99;
      expv = d ^ ltab;
      in_valid = 1'b1;  in_data = d;  in_comp = 1'b0;
      tbl_we = 1'b1;    tbl_sel = 1'b0;  tbl_data = t;
      tick();
      in_valid = 1'b0;
      tbl_we   = 1'b0;
      chk("race_qB_old_entry00", BW'(q_B[15:0]), BW'(16'd16));
      wait_done(ok);
      chk("race_done_seen", BW'(ok), BW'(1));
      tick();
      chk("race_out_data", out_data, expv);
      tick();
      exp_cnt++;
      ltab = t;
      run_block("race_next", rand_blk(), 1'b0, 1'b0);
      chk("race_next_qB_entry00", BW'(q_B[15:0]), BW'(16'd99));

      // Randomized blocks: random delay, done hold, component and in-flight table writes
      for (int n = 0; n < 10; n++) begin
         stub_delay = $urandom_range(3, 9);
         stub_hold  = $urandom_range(0, 3);
         run_block("rand", rand_blk(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      stub_delay = 5;
      stub_hold  = 0;

      // Watchdog abort
      stub_never = 1'b1;
      send_block(rand_blk(), 1'b0, ok);
      chk("to_accept", BW'(ok), BW'(1));
      en_cycles = 0;
      saw_valid = 0;
      for (int i = 0; i < 400 && q_Enable === 1'b1; i++) begin
         en_cycles++;
         if (out_valid === 1'b1) saw_valid = 1;
         tick();
      end
      chk("to_enable_cycles", BW'(en_cycles), BW'(256));
      chk("to_timeout_err", BW'(timeout_err), BW'(1));
      for (int i = 0; i < 3; i++) begin
         if (out_valid === 1'b1) saw_valid = 1;
         tick();
      end
      chk("to_no_out_valid", BW'(saw_valid), BW'(0));
      chk("to_blk_count", BW'(blk_count), BW'(16'(exp_cnt)));
      stub_never = 1'b0;
      run_block("to_next", rand_blk(), 1'b1, 1'b0);
      chk("to_err_sticky", BW'(timeout_err), BW'(1));

      // Asynchronous reset while Enable is high
      stub_delay = 20;
      send_block(rand_blk(), 1'b1, ok);
      chk("rr_accept", BW'(ok), BW'(1));
      tick();
      chk("rr_enable_before", BW'(q_Enable), BW'(1));
      #2;
      reset = 1'b0;
      #1;
      chk("rr_enable", BW'(q_Enable), BW'(0));
      chk("rr_in_ready", BW'(in_ready), BW'(1));
      chk("rr_out_valid", BW'(out_valid), BW'(0));
      chk("rr_qA", q_A, '0);
      chk("rr_qB", q_B, '0);
      chk("rr_out_data", out_data, '0);
      chk("rr_out_comp", BW'(out_comp), BW'(0));
      chk("rr_blk_count", BW'(blk_count), BW'(0));
      chk("rr_timeout_err", BW'(timeout_err), BW'(0));
      @(negedge Clock);
      reset   = 1'b1;
      ltab    = '0;
      ctab    = '0;
      exp_cnt = 0;
      stub_delay = 5;
      tick();
      chk("rr_in_ready_after", BW'(in_ready), BW'(1));
      run_block("rr_next", rand_blk(), 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
